// File: rtl/imm_prefix_gen.sv
// Registered immediate generator with prefix-chunk accumulation for the decode stage.
// Optional sticky error status ports are enabled by defining IMM_PFX_ERR_STATUS_EN.
module imm_prefix_gen #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LO_W    = 12,
  parameter int unsigned SHORT_W = 4,
  parameter int unsigned PFX_W   = 4,
  parameter int unsigned MAX_PFX = 2,
  localparam int unsigned CNT_W  = $clog2(MAX_PFX + 1)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IMM_PFX_ERR_STATUS_EN
  input  logic              err_clr,
  output logic [2:0]        err_status,
`endif
  input  logic              en,
  input  logic              flush,
  input  logic              pfx_load,
  input  logic [PFX_W-1:0]  pfx_data,
  input  logic              use_imm,
  input  logic [2:0]        mode,
  input  logic [LO_W-1:0]   ir_field,
  output logic [DATA_W-1:0] imm,
  output logic              imm_valid,
  output logic              pfx_armed,
  output logic [CNT_W-1:0]  pfx_count,
  output logic              pfx_err
);

  localparam int unsigned ACC_W = MAX_PFX * PFX_W;
  localparam int unsigned RAW_W = ACC_W + LO_W;
  localparam int unsigned EXT_W = (RAW_W > DATA_W) ? RAW_W : DATA_W;

  localparam logic [2:0] ModeZero    = 3'd0;
  localparam logic [2:0] ModeSeShort = 3'd1;
  localparam logic [2:0] ModeSeLong  = 3'd2;
  localparam logic [2:0] ModeZeLong  = 3'd3;
  localparam logic [2:0] ModeUpper   = 3'd4;

  typedef enum logic [1:0] {StIdle, StArmed, StFull} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              imm_valid_q, imm_valid_d;
  logic              pfx_err_q, pfx_err_d;
  // [0] overflow, [1] dropped prefix, [2] prefix together with use_imm
  logic [2:0]        err_set;

  logic [DATA_W-1:0] imm_plain;
  logic [DATA_W-1:0] imm_pfx;
  logic [EXT_W-1:0]  raw_ext;
  logic [EXT_W-1:0]  pfx_ext;
  logic              pfx_mode_ok;

  always_comb begin
    imm_plain = '0;
    case (mode)
      ModeSeShort: imm_plain = DATA_W'($signed(ir_field[SHORT_W-1:0]));
      ModeSeLong:  imm_plain = DATA_W'($signed(ir_field));
      ModeZeLong:  imm_plain = DATA_W'(ir_field);
      ModeUpper:   imm_plain = DATA_W'(ir_field) << (DATA_W - LO_W);
      default:     imm_plain = '0;
    endcase
  end

  // Only the low pfx_count chunks participate; the extension point moves with the count.
  always_comb begin
    int   w;
    logic fill;
    raw_ext = EXT_W'({acc_q, ir_field});
    w       = int'(cnt_q) * int'(PFX_W) + int'(LO_W);
    fill    = (mode == ModeZeLong) ? 1'b0 : raw_ext[w-1];
    pfx_ext = '0;
    for (int i = 0; i < int'(EXT_W); i++) begin
      pfx_ext[i] = (i < w) ? raw_ext[i] : fill;
    end
    imm_pfx = pfx_ext[DATA_W-1:0];
  end

  assign pfx_mode_ok = (mode == ModeSeShort) || (mode == ModeSeLong) || (mode == ModeZeLong);

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    imm_d       = imm_q;
    imm_valid_d = imm_valid_q;
    err_set     = 3'b000;
    if (!en) begin
      // stall: hold everything
    end else if (flush) begin
      cnt_d       = '0;
      acc_d       = '0;
      imm_valid_d = 1'b0;
    end else if (pfx_load) begin
      acc_d       = ACC_W'({acc_q, pfx_data});
      imm_valid_d = 1'b0;
      if (state_q == StFull) begin
        err_set[0] = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (use_imm) err_set[2] = 1'b1;
    end else if (use_imm) begin
      imm_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
      if (state_q != StIdle && pfx_mode_ok) begin
        imm_d = imm_pfx;
      end else begin
        imm_d = imm_plain;
        if (state_q != StIdle) err_set[1] = 1'b1;
      end
    end else begin
      imm_valid_d = 1'b0;
      if (state_q != StIdle) begin
        cnt_d      = '0;
        acc_d      = '0;
        err_set[1] = 1'b1;
      end
    end
    pfx_err_d = |err_set;
    if (cnt_d == '0) begin
      state_d = StIdle;
    end else if (cnt_d == CNT_W'(MAX_PFX)) begin
      state_d = StFull;
    end else begin
      state_d = StArmed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      imm_q       <= '0;
      imm_valid_q <= 1'b0;
      pfx_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      imm_q       <= imm_d;
      imm_valid_q <= imm_valid_d;
      pfx_err_q   <= pfx_err_d;
    end
  end

`ifdef IMM_PFX_ERR_STATUS_EN
  logic [2:0] err_status_q, err_status_d;

  always_comb begin
    err_status_d = err_status_q;
    if (en) begin
      err_status_d = (err_clr ? 3'b000 : err_status_q) | err_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_status_q <= 3'b000;
    end else begin
      err_status_q <= err_status_d;
    end
  end

  assign err_status = err_status_q;
`endif

  assign imm       = imm_q;
  assign imm_valid = imm_valid_q;
  assign pfx_armed = (state_q != StIdle);
  assign pfx_count = cnt_q;
  assign pfx_err   = pfx_err_q;

endmodule

// File: tb/tb_imm_prefix_gen.sv
// Scoreboard bench for imm_prefix_gen at default parameters; a behavioural model pushes
// expected outputs when stimulus is driven and they are compared after the clock edge.
module tb_imm_prefix_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, flush = 1'b0, pfx_load = 1'b0, use_imm = 1'b0;
  logic [3:0]  pfx_data = '0;
  logic [2:0]  mode = '0;
  logic [11:0] ir_field = '0;
  logic [15:0] imm;
  logic        imm_valid, pfx_armed, pfx_err;
  logic [1:0]  pfx_count;
  logic        err_clr = 1'b0;
  logic [2:0]  err_status;

  always #5 clk = ~clk;

  imm_prefix_gen dut (
    .clk       (clk),
    .rst       (rst),
`ifdef IMM_PFX_ERR_STATUS_EN
    .err_clr   (err_clr),
    .err_status(err_status),
`endif
    .en        (en),
    .flush     (flush),
    .pfx_load  (pfx_load),
    .pfx_data  (pfx_data),
    .use_imm   (use_imm),
    .mode      (mode),
    .ir_field  (ir_field),
    .imm       (imm),
    .imm_valid (imm_valid),
    .pfx_armed (pfx_armed),
    .pfx_count (pfx_count),
    .pfx_err   (pfx_err)
  );

`ifndef IMM_PFX_ERR_STATUS_EN
  assign err_status = 3'b000;
`endif

  typedef struct packed {
    logic [15:0] imm;
    logic        val;
    logic [1:0]  cnt;
    logic        err;
    logic [2:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  m_acc = '0;
  int          m_cnt = 0;
  logic [15:0] m_imm = '0;
  logic        m_val = 1'b0;
  logic        m_err = 1'b0;
  logic [2:0]  m_st  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] plain_imm(input logic [2:0] md, input logic [11:0] ir);
    logic [31:0] v;
    case (md)
      3'd1:    v = ir[3] ? (32'hFFFF_FFF0 | {28'd0, ir[3:0]}) : {28'd0, ir[3:0]};
      3'd2:    v = ir[11] ? (32'hFFFF_F000 | {20'd0, ir}) : {20'd0, ir};
      3'd3:    v = {20'd0, ir};
      3'd4:    v = {20'd0, ir} << 4;
      default: v = 32'd0;
    endcase
    return v[15:0];
  endfunction

  function automatic logic [15:0] pfx_imm(input logic [7:0] acc, input int n,
                                          input logic [2:0] md, input logic [11:0] ir);
    int          w;
    logic [31:0] mask, raw;
    w    = 12 + 4 * n;
    mask = (32'd1 << (4 * n)) - 32'd1;
    raw  = (({24'd0, acc} & mask) << 12) | {20'd0, ir};
    if (md != 3'd3 && raw[w-1]) raw = raw | ~((32'd1 << w) - 32'd1);
    return raw[15:0];
  endfunction

  task automatic model_step(input logic e, input logic fl, input logic pl, input logic [3:0] pd,
                            input logic ui, input logic [2:0] md, input logic [11:0] ir,
                            input logic clr);
    logic [2:0] set;
    set = 3'b000;
    if (!e) begin
      // held
    end else if (fl) begin
      m_cnt = 0; m_acc = '0; m_val = 1'b0;
    end else if (pl) begin
      if (m_cnt == 2) set[0] = 1'b1;
      if (ui) set[2] = 1'b1;
      m_acc = {m_acc[3:0], pd};
      if (m_cnt < 2) m_cnt++;
      m_val = 1'b0;
    end else if (ui) begin
      m_val = 1'b1;
      if (m_cnt != 0 && md >= 3'd1 && md <= 3'd3) begin
        m_imm = pfx_imm(m_acc, m_cnt, md, ir);
      end else begin
        m_imm = plain_imm(md, ir);
        if (m_cnt != 0) set[1] = 1'b1;
      end
      m_cnt = 0; m_acc = '0;
    end else begin
      m_val = 1'b0;
      if (m_cnt != 0) begin
        set[1] = 1'b1; m_cnt = 0; m_acc = '0;
      end
    end
    m_err = |set;
    if (e) m_st = (clr ? 3'b000 : m_st) | set;
  endtask

  task automatic model_reset();
    m_acc = '0; m_cnt = 0; m_imm = '0; m_val = 1'b0; m_err = 1'b0; m_st = '0;
  endtask

  task automatic cyc(input logic e, input logic fl, input logic pl, input logic [3:0] pd,
                     input logic ui, input logic [2:0] md, input logic [11:0] ir,
                     input logic clr);
    exp_t x;
    @(negedge clk);
    en = e; flush = fl; pfx_load = pl; pfx_data = pd; use_imm = ui; mode = md;
    ir_field = ir; err_clr = clr;
    model_step(e, fl, pl, pd, ui, md, ir, clr);
    sb_q.push_back('{imm: m_imm, val: m_val, cnt: 2'(m_cnt), err: m_err, st: m_st});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      x = sb_q.pop_front();
      check_eq("imm", 32'(imm), 32'(x.imm));
      check_eq("imm_valid", 32'(imm_valid), 32'(x.val));
      check_eq("pfx_count", 32'(pfx_count), 32'(x.cnt));
      check_eq("pfx_armed", 32'(pfx_armed), 32'(x.cnt != 2'd0));
      check_eq("pfx_err", 32'(pfx_err), 32'(x.err));
`ifdef IMM_PFX_ERR_STATUS_EN
      check_eq("err_status", 32'(err_status), 32'(x.st));
`endif
    end
  endtask

  task automatic pfx(input logic [3:0] d);
    cyc(1'b1, 1'b0, 1'b1, d, 1'b0, 3'd0, 12'h000, 1'b0);
  endtask
  task automatic use_i(input logic [2:0] md, input logic [11:0] ir);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, md, ir, 1'b0);
  endtask
  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 12'h000, 1'b0);
  endtask
  task automatic stall();
    cyc(1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 3'd2, 12'hFFF, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_imm"}, 32'(imm), 32'h0);
    check_eq({tag, "_valid"}, 32'(imm_valid), 32'h0);
    check_eq({tag, "_armed"}, 32'(pfx_armed), 32'h0);
    check_eq({tag, "_count"}, 32'(pfx_count), 32'h0);
    check_eq({tag, "_err"}, 32'(pfx_err), 32'h0);
    check_eq({tag, "_status"}, 32'(err_status), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // sign-extended short, then valid drops
    use_i(3'd1, 12'h00A);
    check_eq("tp2_imm", 32'(imm), 32'hFFFA);
    check_eq("tp2_valid", 32'(imm_valid), 32'h1);
    idle();
    check_eq("tp2_valid_drop", 32'(imm_valid), 32'h0);

    // single prefix with SE_LONG, then un-armed UPPER
    pfx(4'h3);
    check_eq("tp3_armed", 32'(pfx_armed), 32'h1);
    use_i(3'd2, 12'h8AB);
    check_eq("tp3_imm", 32'(imm), 32'h38AB);
    check_eq("tp3_disarm", 32'(pfx_armed), 32'h0);
    use_i(3'd4, 12'h00F);
    check_eq("tp3_upper", 32'(imm), 32'h00F0);

    // overflow shifts out oldest chunk
    pfx(4'h1);
    pfx(4'h2);
    check_eq("tp4_no_err", 32'(pfx_err), 32'h0);
    pfx(4'h5);
    check_eq("tp4_ovf_err", 32'(pfx_err), 32'h1);
    check_eq("tp4_count", 32'(pfx_count), 32'h2);
    use_i(3'd3, 12'hABC);
    check_eq("tp4_imm", 32'(imm), 32'h5ABC);

    // stall holds, flush discards
    pfx(4'h7);
    repeat (3) stall();
    check_eq("tp5_count_held", 32'(pfx_count), 32'h1);
    check_eq("tp5_imm_held", 32'(imm), 32'h5ABC);
    cyc(1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 3'd2, 12'h800, 1'b0);
    check_eq("tp5_flush_count", 32'(pfx_count), 32'h0);
    check_eq("tp5_flush_imm", 32'(imm), 32'h5ABC);
    use_i(3'd3, 12'h123);
    check_eq("tp5_imm", 32'(imm), 32'h0123);
    check_eq("tp5_err", 32'(pfx_err), 32'h0);

    // prefix and use_imm together
    cyc(1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 3'd2, 12'h555, 1'b0);
    check_eq("tp6_err", 32'(pfx_err), 32'h1);
    check_eq("tp6_valid", 32'(imm_valid), 32'h0);
    check_eq("tp6_count", 32'(pfx_count), 32'h1);
`ifdef IMM_PFX_ERR_STATUS_EN
    check_eq("tp6_status", 32'(err_status), 32'h4);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 12'h000, 1'b0);
    check_eq("tp6_status_sticky", 32'(err_status), 32'h4);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 12'h000, 1'b1);
    check_eq("tp6_status_clr", 32'(err_status), 32'h0);
`else
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 12'h000, 1'b0);
`endif

    // invalid-mode consumption while armed: UPPER rule, error pulse
    pfx(4'hC);
    use_i(3'd4, 12'h0AB);
    check_eq("inv_mode_imm", 32'(imm), 32'h0AB0);
    check_eq("inv_mode_err", 32'(pfx_err), 32'h1);

    // asynchronous reset while armed
    pfx(4'hA);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("tp1_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 3), 4'($urandom), ($urandom_range(0, 9) < 4),
          3'($urandom), 12'($urandom), ($urandom_range(0, 7) == 0));
    end

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
